alu_op_sequencer: RTL
=====================

# alu_op_sequencer

Multi-cycle controller that executes one instruction at a time on the team's 4-bit datapath: the 16x4 register file, loaded through a shared 4-bit X bus with per-field strobes, and the 4-bit ALU with carry, sign and zero flags. It accepts instructions over a valid/ready handshake, then sequences the register-file address and data strobes. It captures the ALU result and flags, writes the result back to the destination register, and reports completion with a one-cycle done pulse. It sits between the instruction source (bench or front end) and the register-file/ALU pair.

## Interface
- No parameters; all widths fixed at 4 bits (register index and data).
- clk  in  1  single clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- instr_valid  in  1  instruction present
- instr_ready  out  1  high only in IDLE; instruction accepted on edge with valid&ready
- instr_op  in  3  000 AND, 001 OR, 010 ADD, 011 SUB, 100 LOADI, 101-111 invalid
- instr_rd, instr_rs1, instr_rs2, instr_imm  in  4 each  destination, sources, immediate (LOADI)
- x_bus  out  4  shared address/data bus to register file
- rr1b, rr2b, wrb, wdatab  out  1 each  register-file field strobes (read addr 1, read addr 2, write addr, write data)
- wenable  out  1  register-file write commit
- alu_op  out  2  instr_op[1:0] of the active instruction
- alu_result  in  4; alu_cf, alu_sf, alu_zf  in  1 each  ALU outputs
- done  out  1  one-cycle completion pulse
- result  out  4; cf, sf, zf, invalid  out  1 each  status of last completed instruction, held until next done
- retired  out  8  count of completed instructions, including invalid ones

## Operation
- Latch op/rd/rs1/rs2/imm on acceptance; inputs are ignored afterwards.
- All datapath outputs are flops loaded on the edge entering a state. At most one strobe is high per cycle. x_bus is 0 when no strobe is high.
- FSM states: IDLE, RS1, RS2, WAIT, CAPT, WADDR, WDATA, COMMIT, DONE.
- ALU ops (000-011): IDLE -> RS1 -> RS2 -> WAIT -> CAPT -> WADDR -> WDATA -> COMMIT -> DONE -> IDLE.
  - RS1: x_bus=rs1, rr1b=1.
  - RS2: x_bus=rs2, rr2b=1.
  - WAIT: no strobes; register-file outputs and ALU settle.
  - CAPT: sample alu_result/cf/sf/zf into the result register at the end of the cycle.
  - WADDR: x_bus=rd, wrb=1.
  - WDATA: x_bus=captured result, wdatab=1.
  - COMMIT: wenable=1.
- LOADI: IDLE -> WADDR -> WDATA (x_bus=imm) -> COMMIT -> DONE. result=imm, cf=sf=0, zf=(imm==0).
- Invalid op: IDLE -> DONE directly. No strobes, no wenable. result=0, cf=sf=zf=0, invalid=1.
- invalid=0 for every valid op.
- SUB writes back the ALU magnitude; sf carries the sign. ADD writes the low 4 bits; cf carries bit 4.
- alu_op holds the active instruction's op[1:0] from acceptance until the next acceptance.
- retired increments by 1 on entering DONE and wraps 255 -> 0.

## Timing
- Reset values (asynchronous): state IDLE, instr_ready=1, x_bus=0, all strobes 0, wenable=0, alu_op=0, done=0, result=0, cf=sf=zf=invalid=0, retired=0.
- Acceptance edge is cycle 0.
- done is high in cycle 8 (ALU op), cycle 4 (LOADI), or cycle 1 (invalid).
- result and flags update on the same edge that raises done.
- instr_ready is low from cycle 1 through DONE and returns high in the cycle after DONE. With valid held high, back-to-back ALU ops therefore start every 9 cycles.
- Reset asserted mid-instruction:
  - All outputs go to their reset values immediately.
  - The instruction is abandoned and no done is produced.
  - If reset arrives before COMMIT, no register write occurs.

## Test plan
- Reset with rst_n low for 3 cycles, X on inputs -> all outputs at reset values; instr_ready=1; retired=0.
- LOADI r1=5, LOADI r2=7, then ADD rd=3,rs1=1,rs2=2 -> ADD done at cycle 8 with result=1100, cf=0, zf=0; r3 reads 1100; retired=3.
- LOADI r4=9, LOADI r5=8, ADD r6=r4+r5 -> result=0001, cf=1. SUB r7=r1-r2 (5-7) -> result=0010, sf=1; r7=0010.
- AND r8=r1&(r9 loaded with 1010) -> result=0000, zf=1. op=101 -> done at cycle 1, invalid=1, no strobe or wenable observed.
- Assert rst_n low during WDATA of an ADD -> outputs reset immediately, target register unchanged, no done; next instruction completes normally.
- 256 LOADIs back-to-back with valid held high -> retired wraps to 0; each starts exactly 5 cycles after the previous one.

Source files
------------

// File: rtl/alu_op_sequencer.sv
// Multi-cycle controller for the 4-bit register-file/ALU pair: accepts one instruction,
// drives the X-bus field strobes, captures the ALU result and writes it back.
module alu_op_sequencer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       instr_valid,
  output logic       instr_ready,
  input  logic [2:0] instr_op,
  input  logic [3:0] instr_rd,
  input  logic [3:0] instr_rs1,
  input  logic [3:0] instr_rs2,
  input  logic [3:0] instr_imm,
  output logic [3:0] x_bus,
  output logic       rr1b,
  output logic       rr2b,
  output logic       wrb,
  output logic       wdatab,
  output logic       wenable,
  output logic [1:0] alu_op,
  input  logic [3:0] alu_result,
  input  logic       alu_cf,
  input  logic       alu_sf,
  input  logic       alu_zf,
  output logic       done,
  output logic [3:0] result,
  output logic       cf,
  output logic       sf,
  output logic       zf,
  output logic       invalid,
  output logic [7:0] retired
);

  // Handshake: an instruction is taken on a rising edge where instr_valid && instr_ready;
  // instr_ready is high only in IDLE, and the instruction fields are ignored afterwards.
  typedef enum logic [3:0] {
    S_IDLE, S_RS1, S_RS2, S_WAIT, S_CAPT, S_WADDR, S_WDATA, S_COMMIT, S_DONE
  } state_t;

  state_t     state_q, state_d;
  logic [2:0] op_q, op_d;
  logic [3:0] rd_q, rd_d, rs1_q, rs1_d, rs2_q, rs2_d;
  logic [3:0] capt_q, capt_d;
  logic       capt_cf_q, capt_cf_d, capt_sf_q, capt_sf_d, capt_zf_q, capt_zf_d;
  logic       ready_q, ready_d;
  logic [3:0] x_bus_q, x_bus_d;
  logic       rr1b_q, rr1b_d, rr2b_q, rr2b_d, wrb_q, wrb_d, wdatab_q, wdatab_d;
  logic       wen_q, wen_d;
  logic [1:0] alu_op_q, alu_op_d;
  logic       done_q, done_d;
  logic [3:0] result_q, result_d;
  logic       cf_q, cf_d, sf_q, sf_d, zf_q, zf_d, invalid_q, invalid_d;
  logic [7:0] retired_q, retired_d;

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    rd_d      = rd_q;
    rs1_d     = rs1_q;
    rs2_d     = rs2_q;
    capt_d    = capt_q;
    capt_cf_d = capt_cf_q;
    capt_sf_d = capt_sf_q;
    capt_zf_d = capt_zf_q;
    alu_op_d  = alu_op_q;
    case (state_q)
      S_IDLE: begin
        if (instr_valid) begin
          op_d     = instr_op;
          rd_d     = instr_rd;
          rs1_d    = instr_rs1;
          rs2_d    = instr_rs2;
          alu_op_d = instr_op[1:0];
          // LOADI and invalid ops preload the capture register so WDATA/DONE need no special case
          if (instr_op < 3'd4) begin
            state_d = S_RS1;
          end else if (instr_op == 3'd4) begin
            state_d   = S_WADDR;
            capt_d    = instr_imm;
            capt_cf_d = 1'b0;
            capt_sf_d = 1'b0;
            capt_zf_d = (instr_imm == 4'd0);
          end else begin
            state_d   = S_DONE;
            capt_d    = 4'd0;
            capt_cf_d = 1'b0;
            capt_sf_d = 1'b0;
            capt_zf_d = 1'b0;
          end
        end
      end
      S_RS1:    state_d = S_RS2;
      S_RS2:    state_d = S_WAIT;
      S_WAIT:   state_d = S_CAPT;
      S_CAPT: begin
        state_d   = S_WADDR;
        capt_d    = alu_result;
        capt_cf_d = alu_cf;
        capt_sf_d = alu_sf;
        capt_zf_d = alu_zf;
      end
      S_WADDR:  state_d = S_WDATA;
      S_WDATA:  state_d = S_COMMIT;
      S_COMMIT: state_d = S_DONE;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Datapath outputs are registered versions of what the state being entered requires
  always_comb begin
    ready_d   = (state_d == S_IDLE);
    x_bus_d   = 4'd0;
    rr1b_d    = 1'b0;
    rr2b_d    = 1'b0;
    wrb_d     = 1'b0;
    wdatab_d  = 1'b0;
    wen_d     = 1'b0;
    done_d    = (state_d == S_DONE);
    result_d  = result_q;
    cf_d      = cf_q;
    sf_d      = sf_q;
    zf_d      = zf_q;
    invalid_d = invalid_q;
    retired_d = retired_q;
    case (state_d)
      S_RS1:    begin x_bus_d = rs1_d;  rr1b_d   = 1'b1; end
      S_RS2:    begin x_bus_d = rs2_d;  rr2b_d   = 1'b1; end
      S_WADDR:  begin x_bus_d = rd_d;   wrb_d    = 1'b1; end
      S_WDATA:  begin x_bus_d = capt_d; wdatab_d = 1'b1; end
      S_COMMIT: wen_d = 1'b1;
      default:  ;
    endcase
    if (done_d) begin
      result_d  = capt_d;
      cf_d      = capt_cf_d;
      sf_d      = capt_sf_d;
      zf_d      = capt_zf_d;
      invalid_d = (op_d > 3'd4);
      retired_d = retired_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      op_q      <= 3'd0;
      rd_q      <= 4'd0;
      rs1_q     <= 4'd0;
      rs2_q     <= 4'd0;
      capt_q    <= 4'd0;
      capt_cf_q <= 1'b0;
      capt_sf_q <= 1'b0;
      capt_zf_q <= 1'b0;
      ready_q   <= 1'b1;
      x_bus_q   <= 4'd0;
      rr1b_q    <= 1'b0;
      rr2b_q    <= 1'b0;
      wrb_q     <= 1'b0;
      wdatab_q  <= 1'b0;
      wen_q     <= 1'b0;
      alu_op_q  <= 2'd0;
      done_q    <= 1'b0;
      result_q  <= 4'd0;
      cf_q      <= 1'b0;
      sf_q      <= 1'b0;
      zf_q      <= 1'b0;
      invalid_q <= 1'b0;
      retired_q <= 8'd0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      rd_q      <= rd_d;
      rs1_q     <= rs1_d;
      rs2_q     <= rs2_d;
      capt_q    <= capt_d;
      capt_cf_q <= capt_cf_d;
      capt_sf_q <= capt_sf_d;
      capt_zf_q <= capt_zf_d;
      ready_q   <= ready_d;
      x_bus_q   <= x_bus_d;
      rr1b_q    <= rr1b_d;
      rr2b_q    <= rr2b_d;
      wrb_q     <= wrb_d;
      wdatab_q  <= wdatab_d;
      wen_q     <= wen_d;
      alu_op_q  <= alu_op_d;
      done_q    <= done_d;
      result_q  <= result_d;
      cf_q      <= cf_d;
      sf_q      <= sf_d;
      zf_q      <= zf_d;
      invalid_q <= invalid_d;
      retired_q <= retired_d;
    end
  end

  assign instr_ready = ready_q;
  assign x_bus       = x_bus_q;
  assign rr1b        = rr1b_q;
  assign rr2b        = rr2b_q;
  assign wrb         = wrb_q;
  assign wdatab      = wdatab_q;
  assign wenable     = wen_q;
  assign alu_op      = alu_op_q;
  assign done        = done_q;
  assign result      = result_q;
  assign cf          = cf_q;
  assign sf          = sf_q;
  assign zf          = zf_q;
  assign invalid     = invalid_q;
  assign retired     = retired_q;

endmodule
